// File: rtl/fetch_unit_if.sv
// fetch_unit_if: signal bundle around the RV32I fetch stage.
//   master modport : the fetch unit itself (drives memory requests and the
//                    decoder-facing instruction stream, reads responses,
//                    redirects and decoder ready).
//   slave modport  : the environment (instruction memory, later pipeline
//                    stages and the opcode decoder).
// Signals:
//   imem_req_valid/ready/addr   word request to instruction memory
//   imem_resp_valid/data        in-order response, one per accepted request
//   redirect_valid/pc           branch/jump/trap redirect from later stages
//   instr_valid/ready           head-of-buffer handshake with the decoder
//   instr/instr_pc/opcode       head instruction, its PC and instr[6:0]
//   fetch_fault                 sticky misaligned-redirect flag
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, opcode, fetch_fault,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, opcode, fetch_fault,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: in-order RV32I instruction fetch stage.
//   Holds the fetch PC, issues word requests to a variable-latency
//   instruction memory, buffers returned words in a FIFO and hands them to
//   the opcode decoder over a valid/ready handshake. Redirects flush the
//   FIFO and squash every response still outstanding.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   fu   fetch_unit_if.master (memory, redirect and decoder signals)
// Parameters:
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master fu
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        FETCH,
        FAULT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;

    logic          req_valid;
    logic          req_fire;
    logic          resp_fire;
    logic          pop;
    logic          push;
    logic          drop_active;
    logic          credit_ok;
    logic          misaligned;
    logic [31:0]   redirect_aligned;
    logic          head_valid;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc;

    // Requests in flight plus buffered words never exceed the FIFO size,
    // so every response always has a slot waiting for it.
    assign credit_ok        = ({1'b0, in_flight} + {1'b0, count}) < DEPTH_W;
    assign misaligned       = fu.redirect_pc[1:0] != 2'b00;
    assign redirect_aligned = {fu.redirect_pc[31:2], 2'b00};
    assign drop_active      = drop_cnt != '0;

    assign head_valid = count != '0;
    assign req_fire   = req_valid & fu.imem_req_ready;
    assign resp_fire  = fu.imem_resp_valid;
    assign pop        = head_valid & fu.instr_ready;
    assign push       = !rst & resp_fire & !drop_active & !fu.redirect_valid;

    // Head outputs read as zero while the buffer is empty so stale or
    // never-written entries are not visible to the decoder.
    assign head_instr = head_valid ? data_mem[rd_ptr] : '0;
    assign head_pc    = head_valid ? pc_mem[rd_ptr]   : '0;

    assign fu.imem_req_valid = req_valid;
    assign fu.imem_req_addr  = fetch_pc_q;
    assign fu.instr_valid    = head_valid;
    assign fu.instr          = head_instr;
    assign fu.instr_pc       = head_pc;
    assign fu.opcode         = head_instr[6:0];
    assign fu.fetch_fault    = (state_q == FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        if (fu.redirect_valid) begin
            state_d = misaligned ? FAULT : FETCH;
        end
        if (!rst && state_q == FETCH && !fu.redirect_valid && credit_ok) begin
            req_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_flight  <= '0;
            drop_cnt   <= '0;
        end else if (fu.redirect_valid) begin
            fetch_pc_q <= redirect_aligned;
            resp_pc_q  <= redirect_aligned;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            // No request issues in a redirect cycle and any response in it is
            // discarded, so everything still outstanding afterwards is stale.
            in_flight  <= in_flight - CW'(resp_fire);
            drop_cnt   <= in_flight - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            in_flight <= in_flight + CW'(req_fire) - CW'(resp_fire);
            if (resp_fire && drop_active) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr    <= wr_ptr + PW'(1);
                resp_pc_q <= resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc_q;
            data_mem[wr_ptr] <= fu.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
//   The reference model views fetch as a stream: after reset or a redirect
//   to T the decoder must see T, T+4, ... each paired with the memory word at
//   that address; requests follow the same address stream and obey the
//   credit rule; stale responses never surface.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .fu  (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int          pops  = 0;
    int          lat, p_rdy, p_pop, p_resp, p_redir;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc;

    req_t        q[$];
    int          buf_n;
    logic [31:0] exp_pop_pc;
    logic [31:0] exp_req_addr;
    logic        exp_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0037;
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    task automatic model_reset();
        q.delete();
        buf_n        = 0;
        exp_fault    = 1'b0;
        exp_pop_pc   = RST_PC;
        exp_req_addr = RST_PC;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        // Reset must override a concurrent misaligned redirect and response.
        bus.redirect_valid  = 1'b1;
        bus.redirect_pc     = 32'h0000_0557;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = $urandom;
        bus.imem_req_ready  = 1'b1;
        bus.instr_ready     = 1'b1;
        @(negedge clk);
        #1;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, RST_PC);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_instr_pc", bus.instr_pc, 0);
        check("rst_opcode", {25'd0, bus.opcode}, 0);
        check("rst_fault", bus.fetch_fault, 0);
        rst = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.instr_ready     = 1'b0;
        model_reset();
    endtask

    task automatic step();
        bit          redir;
        bit          resp;
        bit          rv_exp;
        logic [31:0] rpc;
        logic [31:0] w;
        req_t        item;
        @(negedge clk);
        redir = 1'b0;
        rpc   = $urandom;
        if (force_redir) begin
            redir       = 1'b1;
            rpc         = force_pc;
            force_redir = 1'b0;
        end else if ($urandom_range(99) < p_redir) begin
            redir = 1'b1;
            rpc   = $urandom & 32'h0000_0FFC;
            if ($urandom_range(9) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
        end
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = ($urandom_range(99) < p_rdy);
        bus.instr_ready    = ($urandom_range(99) < p_pop);
        resp = (q.size() > 0) && (q[0].due <= cyc) && ($urandom_range(99) < p_resp);
        bus.imem_resp_valid = resp;
        bus.imem_resp_data  = resp ? mem_word(q[0].addr) : $urandom;
        #1;

        check("fetch_fault", bus.fetch_fault, exp_fault);
        check("instr_valid", bus.instr_valid, (buf_n != 0));
        rv_exp = !exp_fault && !redir && (q.size() + buf_n < DEPTH);
        check("req_valid", bus.imem_req_valid, rv_exp);

        if (bus.instr_valid && bus.instr_ready) begin
            w = mem_word(exp_pop_pc);
            check("instr_pc", bus.instr_pc, exp_pop_pc);
            check("instr", bus.instr, w);
            check("opcode", {25'd0, bus.opcode}, {25'd0, w[6:0]});
            exp_pop_pc += 32'd4;
            if (buf_n > 0) buf_n--;
            pops++;
        end
        if (resp) begin
            item = q.pop_front();
            if (!redir && !item.stale) buf_n++;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_req_addr);
            q.push_back('{addr: bus.imem_req_addr, due: cyc + lat, stale: 1'b0});
            exp_req_addr += 32'd4;
        end
        if (redir) begin
            foreach (q[i]) q[i].stale = 1'b1;
            buf_n        = 0;
            exp_fault    = (rpc[1:0] != 2'b00);
            exp_pop_pc   = rpc;
            exp_req_addr = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        force_redir = 1'b1;
        force_pc    = pc;
        step();
    endtask

    initial begin
        int p0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.instr_ready     = 1'b0;
        lat = 1; p_rdy = 100; p_pop = 100; p_resp = 100; p_redir = 0;
        do_reset();

        // Streaming from a single-cycle memory.
        p0 = pops;
        run(30);
        check("stream_pops", (pops - p0 >= 20), 1);

        // Decoder backpressure fills the buffer, then drains in order.
        p_pop = 0;
        run(15);
        check("bp_full_valid", bus.instr_valid, 1);
        p_pop = 100;
        p0 = pops;
        run(10);
        check("bp_drain_pops", (pops - p0 >= 8), 1);

        // Three-cycle memory, redirect with responses outstanding.
        do_reset();
        lat = 3;
        run(3);
        redirect_to(32'h0000_0100);
        p0 = pops;
        run(15);
        check("redir_pops", (pops - p0 >= 5), 1);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        run(6);
        redirect_to(32'h0000_0300);
        run(8);

        // Misaligned redirect faults, aligned redirect recovers.
        redirect_to(32'h0000_0102);
        run(6);
        redirect_to(32'h0000_0200);
        p0 = pops;
        run(10);
        check("fault_recover_pops", (pops - p0 >= 5), 1);

        // Address wrap at the top of the address space.
        redirect_to(32'hFFFF_FFF8);
        p0 = pops;
        run(10);
        check("wrap_pops", (pops - p0 >= 5), 1);

        // Random traffic, a reset in the middle of it, more random traffic.
        p_rdy = 70; p_pop = 60; p_resp = 70; p_redir = 4;
        for (int k = 0; k < 12; k++) begin
            lat = $urandom_range(4, 1);
            run(50);
        end
        do_reset();
        for (int k = 0; k < 6; k++) begin
            lat = $urandom_range(4, 1);
            run(50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- In-order RV32I instruction fetch stage that sits directly upstream of the opcode decoder.
- Holds the PC and issues word requests to instruction memory, which may answer after a variable latency.
- Buffers returned words in a small FIFO and presents them with a valid/ready handshake; the decoder takes instr[6:0] as its opcode input.
- Handles redirects (branch, jump, trap) from later stages by flushing the FIFO and squashing in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least 2.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- imem_req_valid  out  1: request valid.
- imem_req_ready  in  1: memory accepts the request.
- imem_req_addr  out  32: word address (fetch_pc); bits [1:0] are always 0.
- imem_resp_valid  in  1: response data valid; responses return in order, one per accepted request.
- imem_resp_data  in  32: instruction word.
- redirect_valid  in  1: redirect fetch.
- redirect_pc  in  32: new PC.
- instr_valid  out  1: FIFO head valid.
- instr_ready  in  1: decoder consumes the head.
- instr  out  32: head instruction.
- instr_pc  out  32: PC of the head instruction.
- opcode  out  7: instr[6:0], routed straight to the opcode decoder.
- fetch_fault  out  1: misaligned redirect; sticky.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty, in_flight=0, drop_cnt=0, state=FETCH.
  - All outputs 0 except imem_req_addr=RESET_PC and instr_pc=0.
  - Reset overrides any concurrent redirect or response; in-flight responses after reset are not tracked and are the memory's responsibility to cancel.
- Handshake events:
  - req_fire = imem_req_valid & imem_req_ready.
  - pop = instr_valid & instr_ready.
  - resp_fire = imem_resp_valid.
- Request issue: imem_req_valid = (state==FETCH) & !redirect_valid & (in_flight + count < FIFO_DEPTH). This credit rule guarantees the FIFO never overflows. On req_fire, fetch_pc += 4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
- in_flight tracks outstanding requests: in_flight_next = in_flight + req_fire - resp_fire.
- Response handling:
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise: push {resp_pc, imem_resp_data} into the FIFO and set resp_pc += 4.
  - A push and a pop in the same cycle are allowed, including when the FIFO is full; count is unchanged.
- Output timing: instr, instr_pc and opcode come directly from the FIFO head register. Latency is one cycle from resp_fire to instr_valid (no bypass). With zero-latency memory, one instruction per cycle is sustained.
- Redirect (redirect_valid=1) with redirect_pc[1:0]==0:
  - Next cycle: FIFO empty, fetch_pc=resp_pc=redirect_pc.
  - drop_cnt = in_flight + drop_cnt_effect, i.e. every request outstanding after this cycle will be squashed.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is accepted and has no further effect.
  - No request is issued in the redirect cycle.
  - state=FETCH and fetch_fault is cleared.
- Redirect with redirect_pc[1:0]!=0:
  - Same flush and squash as above.
  - state=FAULT, fetch_fault=1, fetch_pc=redirect_pc & ~3.
- FAULT state:
  - No requests are issued.
  - Pending responses are still drained through drop_cnt.
  - The state is left only by an aligned redirect or by rst.
- Back-to-back redirects: each one recomputes drop_cnt from the current in_flight; the last redirect wins.
- Memory stall: imem_req_ready=0 holds imem_req_valid and imem_req_addr stable unless a redirect or credit exhaustion deasserts the request.
- Backpressure: with instr_ready=0, the FIFO fills to FIFO_DEPTH, then requests stop; nothing is lost.

Test Plan:
- Reset with RESET_PC=0 and single-cycle memory returning 32'h0000_0037 (LUI): instr_valid rises 1 cycle after the first response; instr_pc=0, opcode=7'b0110111; subsequent instr_pc values are 4, 8, 12.
- Hold instr_ready=0 with a responsive memory: exactly 4 words enter the FIFO, imem_req_valid drops to 0 while in_flight+count=4; releasing instr_ready yields PCs 0, 4, 8, 12 in order with no gaps or duplicates.
- Memory with 3-cycle latency and 2 outstanding requests, then redirect_pc=32'h100: both stale responses are discarded; the first instr_pc after the redirect is 32'h100 and its data comes from the first post-redirect request.
- Redirect asserted in the same cycle as a response and as a pop: FIFO empties, the response is dropped, and the next instr_pc is the redirect target.
- redirect_pc=32'h102: fetch_fault=1 and no requests are issued; a following redirect_pc=32'h200 clears the fault and fetch resumes at 32'h200.
- fetch_pc=32'hFFFF_FFFC: the next request address wraps to 32'h0000_0000.
